// File: rtl/pc_sequencer.sv
// Program-counter successor for the fetch stage: increment, absolute jump,
// PC-relative branch and call/return through a small return-address stack.
module pc_sequencer #(
  parameter int unsigned          PC_WIDTH     = 8,
  parameter int unsigned          STACK_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pc_enable,
  input  logic                                 pc_load,
  input  logic                                 pc_call,
  input  logic                                 pc_ret,
  input  logic                                 pc_branch,
  input  logic [PC_WIDTH-1:0]                  pc_in,
  input  logic [PC_WIDTH-1:0]                  pc_offset,
  output logic [PC_WIDTH-1:0]                  pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_count,
  output logic                                 stack_overflow,
  output logic                                 stack_underflow
);

  localparam int unsigned CW        = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW        = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned RAS_SLOTS = 2 ** AW;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic [PC_WIDTH-1:0] ras [RAS_SLOTS];
  logic [PC_WIDTH-1:0] pc_inc;
  logic                ras_full, ras_empty, push;
  logic [AW-1:0]       wr_idx, rd_idx;

  // Next-state selection; priority load > call > ret > branch > increment.
  always_comb begin
    pc_d      = pc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    pc_inc    = pc_q + PC_WIDTH'(1);
    ras_full  = (count_q == CW'(STACK_DEPTH));
    ras_empty = (count_q == '0);
    wr_idx    = AW'(count_q);
    rd_idx    = AW'(count_q - CW'(1));

    if (pc_enable) begin
      if (pc_load) begin
        pc_d = pc_in;
      end else if (pc_call) begin
        pc_d = pc_in;
        if (ras_full) begin
          ovf_d = 1'b1;
        end else begin
          push    = 1'b1;
          count_d = count_q + CW'(1);
        end
      end else if (pc_ret) begin
        if (ras_empty) begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end else begin
          pc_d    = ras[rd_idx];
          count_d = count_q - CW'(1);
        end
      end else if (pc_branch) begin
        // Unsigned modulo add is identical to a signed offset in two's complement.
        pc_d = pc_q + pc_offset;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_VECTOR;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && reset) begin
      ras[wr_idx] <= pc_inc;
    end
  end

  assign pc_out          = pc_q;
  assign stack_count     = count_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule
